// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcode map, run-state value, opcode classes.
// Defining EX_OVF_FLAG_EN enables the signed-overflow flag (vf) and the BV/BNV branches.
package ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam logic EXEC = 1'b1;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_HALT  = 5'd1,
    OP_LOAD  = 5'd2,
    OP_STORE = 5'd3,
    OP_LDIH  = 5'd4,
    OP_ADD   = 5'd5,
    OP_ADDI  = 5'd6,
    OP_ADDC  = 5'd7,
    OP_SUB   = 5'd8,
    OP_SUBI  = 5'd9,
    OP_SUBC  = 5'd10,
    OP_CMP   = 5'd11,
    OP_AND   = 5'd12,
    OP_OR    = 5'd13,
    OP_XOR   = 5'd14,
    OP_SLL   = 5'd15,
    OP_SRL   = 5'd16,
    OP_SLA   = 5'd17,
    OP_SRA   = 5'd18,
    OP_JUMP  = 5'd19,
    OP_JMPR  = 5'd20,
    OP_BZ    = 5'd21,
    OP_BNZ   = 5'd22,
    OP_BN    = 5'd23,
    OP_BNN   = 5'd24,
    OP_BC    = 5'd25,
    OP_BNC   = 5'd26,
    OP_BV    = 5'd27,
    OP_BNV   = 5'd28
  } opcode_t;

  function automatic opcode_t decode_op(input logic [DATA_W-1:0] ir);
    return opcode_t'(ir[15:11]);
  endfunction

  function automatic logic is_add_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_ADDC);
  endfunction

  function automatic logic is_sub_op(input opcode_t op);
    return (op == OP_SUB) || (op == OP_SUBI) || (op == OP_SUBC) || (op == OP_CMP);
  endfunction

  function automatic logic is_logic_op(input opcode_t op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  function automatic logic is_shift_op(input opcode_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SLA) || (op == OP_SRA);
  endfunction

  function automatic logic sets_flags(input opcode_t op);
    return is_add_op(op) || is_sub_op(op) || is_logic_op(op) || is_shift_op(op);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational 16-bit ALU of the execute stage: result, carry/borrow and signed overflow.
// The carry-in is consumed only by ADDC and SUBC.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf
);

  opcode_t            opc;
  logic               add_cin;
  logic               sub_bin;
  logic [16:0]        sum;
  logic [16:0]        diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [3:0]         amt;
  logic [16:0]        sll_full;
  logic [16:0]        srl_full;
  logic signed [16:0] sra_in;
  logic signed [16:0] sra_full;
  logic [14:0]        sla_body;
  logic [3:0]         sla_idx;
  logic               sla_out;

  assign opc     = opcode_t'(op);
  assign add_cin = (opc == OP_ADDC) ? cin : 1'b0;
  assign sub_bin = (opc == OP_SUBC) ? cin : 1'b0;
  assign sum     = {1'b0, a} + {1'b0, b} + {16'd0, add_cin};
  assign diff    = {1'b0, a} - {1'b0, b} - {16'd0, sub_bin};
  assign add_ovf = (a[15] == b[15]) && (sum[15] != a[15]);
  assign sub_ovf = (a[15] != b[15]) && (diff[15] != a[15]);

  // Shifters carry one guard bit so the last bit shifted out lands in cout (0 for amount 0)
  assign amt      = b[3:0];
  assign sll_full = {1'b0, a} << amt;
  assign srl_full = {a, 1'b0} >> amt;
  assign sra_in   = {a, 1'b0};
  assign sra_full = sra_in >>> amt;
  assign sla_body = a[14:0] << amt;
  assign sla_idx  = 4'd15 - amt;
  assign sla_out  = (amt == 4'd0) ? 1'b0 : a[sla_idx];

  always_comb begin
    result = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    case (opc)
      OP_ADD, OP_ADDI, OP_ADDC: begin
        result = sum[15:0];
        cout   = sum[16];
        ovf    = add_ovf;
      end
      OP_LOAD, OP_STORE, OP_LDIH, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_BV, OP_BNV: begin
        result = sum[15:0];
      end
      OP_SUB, OP_SUBI, OP_SUBC, OP_CMP: begin
        result = diff[15:0];
        cout   = diff[16];
        ovf    = sub_ovf;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLL: begin
        result = sll_full[15:0];
        cout   = sll_full[16];
      end
      OP_SRL: begin
        result = srl_full[16:1];
        cout   = srl_full[0];
      end
      OP_SLA: begin
        result = {a[15], sla_body};
        cout   = sla_out;
      end
      OP_SRA: begin
        result = sra_full[16:1];
        cout   = sra_full[0];
      end
      OP_JUMP: result = b;
      default: begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, zero/negative/carry flags, branch resolution and the EX/MEM latch.
// Defining EX_OVF_FLAG_EN adds the vf overflow flag output and the BV/BNV branches.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] ex_ir,
  input  logic [15:0] reg_A,
  input  logic [15:0] reg_B,
  input  logic [15:0] smdr,
  output logic [15:0] mem_ir,
  output logic [15:0] reg_C,
  output logic [15:0] smdr1,
  output logic        dw,
  output logic        zf,
  output logic        nf,
  output logic        cf,
`ifdef EX_OVF_FLAG_EN
  output logic        vf,
`endif
  output logic        branch_taken,
  output logic [15:0] branch_target
);

  opcode_t     op;
  logic        run;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_ovf;
  logic        cond;

  assign op  = decode_op(ex_ir);
  assign run = (state == EXEC);

  ex_alu u_alu (
    .op     (ex_ir[15:11]),
    .a      (reg_A),
    .b      (reg_B),
    .cin    (cf),
    .result (alu_result),
    .cout   (alu_cout),
    .ovf    (alu_ovf)
  );

`ifndef EX_OVF_FLAG_EN
  logic ovf_unused;
  assign ovf_unused = alu_ovf;
`endif

  // Branch conditions look at the flags registered by the previous instruction
  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BZ:            cond = zf;
      OP_BNZ:           cond = !zf;
      OP_BN:            cond = nf;
      OP_BNN:           cond = !nf;
      OP_BC:            cond = cf;
      OP_BNC:           cond = !cf;
`ifdef EX_OVF_FLAG_EN
      OP_BV:            cond = vf;
      OP_BNV:           cond = !vf;
`endif
      OP_JUMP, OP_JMPR: cond = 1'b1;
      default:          cond = 1'b0;
    endcase
  end

  assign branch_taken  = run && cond;
  assign branch_target = alu_result;

  // EX/MEM boundary
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ir <= '0;
      reg_C  <= '0;
      smdr1  <= '0;
      dw     <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
    end else if (run) begin
      mem_ir <= ex_ir;
      reg_C  <= alu_result;
      smdr1  <= smdr;
      dw     <= (op == OP_STORE);
      if (sets_flags(op)) begin
        zf <= (alu_result == 16'd0);
        nf <= alu_result[15];
        cf <= alu_cout;
      end
    end
  end

`ifdef EX_OVF_FLAG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vf <= 1'b0;
    end else if (run && sets_flags(op)) begin
      vf <= alu_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: hand-computed vectors checked with immediate assertions.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        state;
  logic [15:0] ex_ir, reg_A, reg_B, smdr;
  logic [15:0] mem_ir, reg_C, smdr1, branch_target;
  logic        dw, zf, nf, cf, branch_taken;
`ifdef EX_OVF_FLAG_EN
  logic        vf;
`endif

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clock         (clock),
    .reset         (reset),
    .state         (state),
    .ex_ir         (ex_ir),
    .reg_A         (reg_A),
    .reg_B         (reg_B),
    .smdr          (smdr),
    .mem_ir        (mem_ir),
    .reg_C         (reg_C),
    .smdr1         (smdr1),
    .dw            (dw),
    .zf            (zf),
    .nf            (nf),
    .cf            (cf),
`ifdef EX_OVF_FLAG_EN
    .vf            (vf),
`endif
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] word(input opcode_t op);
    return {op, 11'h05a};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input opcode_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] s);
    ex_ir = word(op);
    reg_A = a;
    reg_B = b;
    smdr  = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic n, input logic c);
    chk({tag, "_zf"}, {15'd0, zf}, {15'd0, z});
    chk({tag, "_nf"}, {15'd0, nf}, {15'd0, n});
    chk({tag, "_cf"}, {15'd0, cf}, {15'd0, c});
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_mem_ir"}, mem_ir, 16'h0000);
    chk({tag, "_reg_C"}, reg_C, 16'h0000);
    chk({tag, "_smdr1"}, smdr1, 16'h0000);
    chk({tag, "_dw"}, {15'd0, dw}, 16'h0000);
    chk_flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    state = 1'b0;
    ex_ir = '0;
    reg_A = '0;
    reg_B = '0;
    smdr  = '0;
    #1;
    chk_clear("por");
    @(negedge clock);
    reset = 1'b1;
    state = EXEC;

    // ADD overflowing to zero, then ADDC consuming the fresh carry
    drive(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000);
    tick();
    chk("add_reg_C", reg_C, 16'h0000);
    chk("add_mem_ir", mem_ir, word(OP_ADD));
    chk_flags("add", 1'b1, 1'b0, 1'b1);
    drive(OP_ADDC, 16'h0001, 16'h0001, 16'h0000);
    tick();
    chk("addc_reg_C", reg_C, 16'h0003);
    chk_flags("addc", 1'b0, 1'b0, 1'b0);

    // CMP with borrow, then BC sees the new carry with no bubble
    drive(OP_CMP, 16'h0003, 16'h0005, 16'h0000);
    tick();
    chk("cmp_reg_C", reg_C, 16'hFFFE);
    chk_flags("cmp", 1'b0, 1'b1, 1'b1);
    drive(OP_BC, 16'h0100, 16'h0010, 16'h0000);
    chk("bc_taken", {15'd0, branch_taken}, 16'h0001);
    chk("bc_target", branch_target, 16'h0110);
    tick();
    chk("bc_reg_C", reg_C, 16'h0110);
    chk_flags("bc_hold", 1'b0, 1'b1, 1'b1);

    // Shifts
    drive(OP_SRA, 16'h8001, 16'h0001, 16'h0000);
    tick();
    chk("sra_reg_C", reg_C, 16'hC000);
    chk_flags("sra", 1'b0, 1'b1, 1'b1);
    drive(OP_SLA, 16'hC001, 16'h0004, 16'h0000);
    tick();
    chk("sla_reg_C", reg_C, 16'h8010);
    chk_flags("sla", 1'b0, 1'b1, 1'b0);

    // STORE / LOAD
    drive(OP_STORE, 16'h0020, 16'h0003, 16'hBEEF);
    tick();
    chk("st_reg_C", reg_C, 16'h0023);
    chk("st_smdr1", smdr1, 16'hBEEF);
    chk("st_dw", {15'd0, dw}, 16'h0001);
    chk_flags("st", 1'b0, 1'b1, 1'b0);
    drive(OP_LOAD, 16'h0010, 16'h0002, 16'h1234);
    tick();
    chk("ld_reg_C", reg_C, 16'h0012);
    chk("ld_dw", {15'd0, dw}, 16'h0000);
    chk("ld_smdr1", smdr1, 16'h1234);
    chk_flags("ld", 1'b0, 1'b1, 1'b0);

    // Stall: three non-exec cycles with changing inputs
    state = 1'b0;
    drive(OP_JUMP, 16'h1111, 16'h0040, 16'hAAAA);
    chk("stall_jump_taken", {15'd0, branch_taken}, 16'h0000);
    tick();
    drive(OP_ADD, 16'hFFFF, 16'h0001, 16'hBBBB);
    tick();
    drive(OP_STORE, 16'h0005, 16'h0006, 16'hCCCC);
    chk("stall_store_taken", {15'd0, branch_taken}, 16'h0000);
    tick();
    chk("stall_reg_C", reg_C, 16'h0012);
    chk("stall_mem_ir", mem_ir, word(OP_LOAD));
    chk("stall_smdr1", smdr1, 16'h1234);
    chk("stall_dw", {15'd0, dw}, 16'h0000);
    chk_flags("stall", 1'b0, 1'b1, 1'b0);
    state = EXEC;

    // JUMP / BZ not taken
    drive(OP_JUMP, 16'h9999, 16'h0040, 16'h0000);
    chk("jump_taken", {15'd0, branch_taken}, 16'h0001);
    chk("jump_target", branch_target, 16'h0040);
    tick();
    drive(OP_BZ, 16'h0100, 16'h0004, 16'h0000);
    chk("bz_nt_taken", {15'd0, branch_taken}, 16'h0000);
    tick();
    chk("bz_nt_reg_C", reg_C, 16'h0104);

    // SUB borrow, SUBC consuming it, XOR clearing carry, BZ taken
    drive(OP_SUB, 16'h0000, 16'h0001, 16'h0000);
    tick();
    chk("sub_reg_C", reg_C, 16'hFFFF);
    chk_flags("sub", 1'b0, 1'b1, 1'b1);
    drive(OP_SUBC, 16'h0005, 16'h0001, 16'h0000);
    tick();
    chk("subc_reg_C", reg_C, 16'h0003);
    chk_flags("subc", 1'b0, 1'b0, 1'b0);
    drive(OP_SUB, 16'h0000, 16'h0001, 16'h0000);
    tick();
    drive(OP_XOR, 16'hF0F0, 16'hF0F0, 16'h0000);
    tick();
    chk("xor_reg_C", reg_C, 16'h0000);
    chk_flags("xor", 1'b1, 1'b0, 1'b0);
    drive(OP_BZ, 16'h0200, 16'h0008, 16'h0000);
    chk("bz_taken", {15'd0, branch_taken}, 16'h0001);
    chk("bz_target", branch_target, 16'h0208);
    tick();

    // Shift-out carry and zero shift amount
    drive(OP_SLL, 16'h8000, 16'h0001, 16'h0000);
    tick();
    chk("sll_reg_C", reg_C, 16'h0000);
    chk_flags("sll", 1'b1, 1'b0, 1'b1);
    drive(OP_SRL, 16'h0003, 16'h0000, 16'h5555);
    tick();
    chk("srl0_reg_C", reg_C, 16'h0003);
    chk_flags("srl0", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk_clear("async_rst");
    @(negedge clock);
    reset = 1'b1;
    state = 1'b0;
    tick();
    chk("post_rst_reg_C", reg_C, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit five-stage pipeline, directly downstream of instruction decode. Consumes the decoded instruction word and operands (ex_ir, reg_A, reg_B, smdr), performs the ALU operation, maintains the zero/negative/carry flag registers, resolves branches and jumps, and registers results into the EX/MEM pipeline latch (mem_ir, reg_C, smdr1, dw) for the memory stage.

## Interface
- No parameters; data width fixed at 16, opcode field ir[15:11].
- clock  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all registers.
- state  in  1  CPU run state; latch and flags advance only when state == `exec`.
- ex_ir  in  16  instruction from decode.
- reg_A  in  16  first operand (register value).
- reg_B  in  16  second operand (register or zero-extended/shifted immediate; shift amount in [3:0]).
- smdr  in  16  store data from decode.
- mem_ir  out  16  registered instruction to memory stage.
- reg_C  out  16  registered ALU result / memory address / branch target.
- smdr1  out  16  registered store data.
- dw  out  1  registered data-memory write enable (STORE only).
- zf, nf, cf  out  1  flag registers.
- branch_taken  out  1  combinational redirect request to fetch.
- branch_target  out  16  combinational redirect address.

## Operation
- ALU result by opcode: ADD/ADDI/LOAD/STORE/LDIH/JMPR and all conditional branches: A+B. ADDC: A+B+cf. SUB/SUBI/CMP: A−B. SUBC: A−B−cf. AND/OR/XOR: bitwise. SLL/SRL: logical shift by B[3:0]. SLA: left shift by B[3:0], bit 15 preserved. SRA: arithmetic right shift by B[3:0]. JUMP: B. NOP/HALT/unknown: 0.
- Carry: add ops cf = carry out of bit 15 (17-bit sum). Subtract ops cf = 1 on unsigned borrow (17-bit difference bit 16). Logic ops: cf = 0. Shifts: cf = last bit shifted out; amount 0 → cf = 0.
- zf = (result == 0); nf = result[15].
- Flags updated only for ADD, ADDC, ADDI, SUB, SUBC, SUBI, CMP, AND, OR, XOR, SLL, SRL, SLA, SRA. All other opcodes hold flags.
- Branch conditions use current flag registers (pre-update): BZ zf, BNZ !zf, BN nf, BNN !nf, BC cf, BNC !cf. JUMP and JMPR unconditional. branch_target = ALU result; branch_taken = 0 for all other opcodes and when state != `exec`.
- On each `exec` edge: mem_ir ← ex_ir, reg_C ← ALU result, smdr1 ← smdr, dw ← (opcode == STORE).
- CMP produces reg_C and flags; writeback ignores its result.

## Timing
- Reset (async, any time, including mid-pipeline): mem_ir, reg_C, smdr1 = 0; dw, zf, nf, cf = 0. Effect immediate, not clock-aligned.
- Latency: one cycle; EX/MEM outputs valid after the edge on which the instruction sat in EX.
- state != `exec`: every register holds; branch_taken forced 0.
- Back-to-back flag use: flag-setting instruction updates flags at its EX edge; an immediately following branch sees the new flags with no bubble.
- Simultaneous ADDC/SUBC after a carry-producing op consumes the just-registered cf.
- ALU and branch outputs are purely combinational from ex_ir/reg_A/reg_B/flags; no combinational path from clock or reset to reg_C.

## Configuration
- EX_OVF_FLAG_EN defined: adds output vf (1 bit) and its register, reset 0; set to signed two's-complement overflow for add/subtract ops, cleared for logic and shift ops, held otherwise; adds branches BV/BNV if their opcodes exist in the shared define header.
- Undefined: no vf port, no register; signed overflow is not tracked.

## Structure
- Opcode constants, `exec` state value and the EX_OVF_FLAG_EN guard belong in the shared define header used by all stages.
- One sub-module: ex_alu, combinational (opcode, A, B, cin → result, cout, ovf). ex_stage holds flags, branch logic and the EX/MEM latch.

## Test plan
- reset low mid-run with nonzero latch → all outputs 0 immediately, before next clock edge.
- ADD A=0xFFFF B=0x0001 → reg_C=0x0000, zf=1, cf=1, nf=0; next ADDC A=0x0001 B=0x0001 → reg_C=0x0003, cf=0.
- CMP A=0x0003 B=0x0005 → reg_C=0xFFFE, nf=1, cf=1; following BC A=0x0100 B=0x0010 → branch_taken=1, branch_target=0x0110.
- SRA A=0x8001 B=0x0001 → reg_C=0xC000, cf=1; SLA A=0xC001 B=0x0004 → reg_C=0x8010 (bit 15 kept).
- STORE A=0x0020 B=0x0003 smdr=0xBEEF → reg_C=0x0023, smdr1=0xBEEF, dw=1; next LOAD → dw=0, flags unchanged.
- state != `exec` for 3 cycles with changing inputs → outputs and flags hold; branch_taken=0 even for JUMP.
